// File: rtl/note_vol_ramp_bank.sv
// note_vol_ramp_bank: Avalon-MM register bank of per-voice target volumes.
// On each sample tick, a sequencer visits every channel once. Each visit slews
// the channel's current volume toward its target by the programmed step. The
// result is scaled by the master volume through one shared multiplier.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   avs_address        word address (targets, master, step, status, control)
//   avs_write          write strobe, with avs_writedata
//   avs_read           read strobe; avs_readdata is valid one cycle later
//   sample_tick        one-cycle pulse per audio sample; starts a sweep
//   vol_out            scaled volumes; channel k is at [k*VOL_W +: VOL_W]
//   frame_done         one-cycle pulse when a sweep completes
//   ramp_busy          registered OR of (current != target) over all channels
module note_vol_ramp_bank #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned VOL_W    = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [VOL_W-1:0] STEP_RST = VOL_W'(16'h0100)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         avs_address,
    input  logic                      avs_write,
    input  logic [31:0]               avs_writedata,
    input  logic                      avs_read,
    output logic [31:0]               avs_readdata,
    input  logic                      sample_tick,
    output logic [NUM_CH*VOL_W-1:0]   vol_out,
    output logic                      frame_done,
    output logic                      ramp_busy
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = VOL_W + 9;
    localparam logic [ADDR_W-1:0] A_MASTER = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_CH + 2);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_CH + 3);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FINISH} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VOL_W-1:0]   tgt_q [NUM_CH];
    logic [VOL_W-1:0]   tgt_d [NUM_CH];
    logic [VOL_W-1:0]   cur_q [NUM_CH];
    logic [VOL_W-1:0]   cur_d [NUM_CH];
    logic [VOL_W-1:0]   vol_q [NUM_CH];
    logic [VOL_W-1:0]   vol_d [NUM_CH];
    logic [7:0]         master_q, master_d;
    logic [VOL_W-1:0]   step_q, step_d;
    logic               overrun_q, overrun_d;
    logic               snap_q, snap_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               slot_en;

    logic [VOL_W-1:0]   cur_sel, tgt_sel, cur_new, scaled;
    logic [VOL_W:0]     sum;
    logic [8:0]         master_p1;
    logic [PROD_W-1:0]  prod;

    // Sequencer: IDLE -> one slot per channel -> FINISH (frame_done) -> IDLE
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        slot_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                slot_en = 1'b1;
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_FINISH: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared channel datapath: slew the selected channel and scale it by master
    always_comb begin
        cur_sel = '0;
        tgt_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_sel = cur_q[k];
                tgt_sel = tgt_q[k];
            end
        end
        sum = {1'b0, cur_sel} + {1'b0, step_q};
        if (snap_q) begin
            cur_new = tgt_sel;
        end else if (cur_sel < tgt_sel) begin
            cur_new = (sum > {1'b0, tgt_sel}) ? tgt_sel : sum[VOL_W-1:0];
        end else if (cur_sel > tgt_sel) begin
            // cur > tgt, so cur - tgt cannot underflow; clamp at target
            cur_new = ((cur_sel - tgt_sel) > step_q) ? (cur_sel - step_q) : tgt_sel;
        end else begin
            cur_new = cur_sel;
        end
        master_p1 = {1'b0, master_q} + 9'd1;
        prod      = PROD_W'(cur_new) * PROD_W'(master_p1);
        scaled    = prod[VOL_W+7:8];
    end

    // Register-bank next state, channel writeback, status and read mux
    always_comb begin
        master_d  = master_q;
        step_d    = step_q;
        snap_d    = snap_q;
        busy_d    = 1'b0;
        rdata_d   = '0;
        overrun_d = overrun_q;
        for (int k = 0; k < NUM_CH; k++) begin
            tgt_d[k] = tgt_q[k];
            cur_d[k] = cur_q[k];
            vol_d[k] = vol_q[k];
            if (avs_write && avs_address == ADDR_W'(k)) begin
                tgt_d[k] = avs_writedata[VOL_W-1:0];
            end
            if (slot_en && idx_q == IDX_W'(k)) begin
                cur_d[k] = cur_new;
                vol_d[k] = scaled;
            end
            busy_d = busy_d | (cur_q[k] != tgt_q[k]);
        end
        if (avs_write && avs_address == A_MASTER) begin
            master_d = avs_writedata[7:0];
        end
        if (avs_write && avs_address == A_STEP) begin
            step_d = (avs_writedata[VOL_W-1:0] == '0) ? VOL_W'(1) : avs_writedata[VOL_W-1:0];
        end
        // A snap request landing in FINISH still applies to the next sweep
        if (state_q == S_FINISH) begin
            snap_d = 1'b0;
        end
        if (avs_write && avs_address == A_CTRL && avs_writedata[1]) begin
            snap_d = 1'b1;
        end
        // Clear first so a same-cycle dropped tick wins
        if (avs_write && avs_address == A_CTRL && avs_writedata[0]) begin
            overrun_d = 1'b0;
        end
        if (sample_tick && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end
        if (avs_read) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (avs_address == ADDR_W'(k)) begin
                    rdata_d = 32'(tgt_q[k]);
                end
            end
            if (avs_address == A_MASTER) rdata_d = 32'(master_q);
            if (avs_address == A_STEP)   rdata_d = 32'(step_q);
            if (avs_address == A_STATUS) rdata_d = {30'd0, overrun_q, busy_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            master_q     <= 8'hFF;
            step_q       <= STEP_RST;
            overrun_q    <= 1'b0;
            snap_q       <= 1'b0;
            rdata_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                tgt_q[k] <= '0;
                cur_q[k] <= '0;
                vol_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            master_q     <= master_d;
            step_q       <= step_d;
            overrun_q    <= overrun_d;
            snap_q       <= snap_d;
            rdata_q      <= rdata_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            for (int k = 0; k < NUM_CH; k++) begin
                tgt_q[k] <= tgt_d[k];
                cur_q[k] <= cur_d[k];
                vol_q[k] <= vol_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_vol
        assign vol_out[g*VOL_W +: VOL_W] = vol_q[g];
    end

    assign avs_readdata = rdata_q;
    assign frame_done   = frame_done_q;
    assign ramp_busy    = busy_q;

    // Upper write-data bits and product bits outside the scaled window are unused
    logic unused_ok;
    assign unused_ok = ^{avs_writedata, prod};

endmodule

// File: tb/tb_note_vol_ramp_bank.sv
// Directed bench for note_vol_ramp_bank (NUM_CH=8, VOL_W=16): register-map and
// ramp vectors from a table, plus hand sequences for overrun, snap and reset.
module tb_note_vol_ramp_bank;

    localparam int NCH = 8;
    localparam int VW  = 16;
    localparam int LAT = NCH + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              sample_tick;
    logic [NCH*VW-1:0] vol_out;
    logic              frame_done;
    logic              ramp_busy;

    note_vol_ramp_bank dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .sample_tick   (sample_tick),
        .vol_out       (vol_out),
        .frame_done    (frame_done),
        .ramp_busy     (ramp_busy)
    );

    always #5 clk = ~clk;

    typedef enum int {V_WR, V_RD, V_TICK, V_VOL, V_BUSY} kind_e;
    typedef struct {
        kind_e       kind;
        int          addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(kind_e k, int a, logic [31:0] d, logic [31:0] e);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_write(int a, logic [31:0] d);
        @(negedge clk);
        avs_address = 5'(a); avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic do_read(int a, output logic [31:0] d);
        @(negedge clk);
        avs_address = 5'(a); avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // Pulse a tick and return the number of cycles until frame_done (bounded)
    task automatic do_tick(output int lat);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 0;
        while (!frame_done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [31:0] rd;
    int          lat;
    int          pulses;

    initial begin
        reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_vol_out_zero", 32'(vol_out != '0), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_ramp_busy", 32'(ramp_busy), 32'd0);

        // Reset register values
        add(V_RD, 8, 0, 32'h0000_00FF);
        add(V_RD, 9, 0, 32'h0000_0100);
        add(V_RD, 10, 0, 32'h0);
        // Ramp up ch2 toward 0x350 in steps of 0x100
        add(V_WR, 2, 32'h350, 0);
        add(V_WR, 9, 32'h100, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 2, 0, 32'h100);
        add(V_BUSY, 0, 0, 1);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 2, 0, 32'h200);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 2, 0, 32'h300);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 2, 0, 32'h350);
        add(V_BUSY, 0, 0, 0);
        add(V_RD, 2, 0, 32'h350);
        // Ramp ch0 down from 5 with step written as 0 (stored as 1)
        add(V_WR, 0, 32'h5, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 0, 0, 32'h5);
        add(V_WR, 0, 32'h0, 0);
        add(V_WR, 9, 32'h0, 0);
        add(V_RD, 9, 0, 32'h1);
        for (int i = 4; i >= 0; i--) begin
            add(V_TICK, 0, 0, LAT);
            add(V_VOL, 0, 0, 32'(i));
        end
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 0, 0, 32'h0);
        add(V_VOL, 2, 0, 32'h350);
        // Master scaling on ch1 = 0x8000 (snapped) and ch2 = 0x350
        add(V_WR, 1, 32'h8000, 0);
        add(V_WR, 11, 32'h2, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 1, 0, 32'h8000);
        add(V_WR, 8, 32'h7F, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 1, 0, 32'h4000);
        add(V_VOL, 2, 0, 32'h1A8);
        add(V_WR, 8, 32'h00, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 1, 0, 32'h80);
        add(V_VOL, 2, 0, 32'h3);
        add(V_WR, 8, 32'hFF, 0);
        add(V_TICK, 0, 0, LAT);
        add(V_VOL, 1, 0, 32'h8000);
        add(V_RD, 1, 0, 32'h8000);
        // Status, unmapped and write-only addresses
        add(V_RD, 10, 0, 32'h0);
        add(V_RD, 12, 0, 32'h0);
        add(V_WR, 13, 32'hDEAD_BEEF, 0);
        add(V_RD, 13, 0, 32'h0);
        add(V_RD, 11, 0, 32'h0);

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                V_WR: do_write(vecs[i].addr, vecs[i].data);
                V_RD: begin
                    do_read(vecs[i].addr, rd);
                    chk($sformatf("vec%0d_read_a%0d", i, vecs[i].addr), rd, vecs[i].exp);
                end
                V_TICK: begin
                    do_tick(lat);
                    chk($sformatf("vec%0d_frame_latency", i), 32'(lat), vecs[i].exp);
                end
                V_VOL: chk($sformatf("vec%0d_vol_ch%0d", i, vecs[i].addr),
                           32'(vol_out[vecs[i].addr*VW +: VW]), vecs[i].exp);
                V_BUSY: chk($sformatf("vec%0d_ramp_busy", i), 32'(ramp_busy), vecs[i].exp);
                default: ;
            endcase
        end

        // Overrun: second tick 3 cycles after the first is dropped
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (frame_done) pulses++;
            @(negedge clk);
        end
        chk("overrun_single_sweep", 32'(pulses), 32'd1);
        do_read(10, rd);
        chk("overrun_status_set", rd, 32'h2);
        do_write(11, 32'h1);
        do_read(10, rd);
        chk("overrun_status_cleared", rd, 32'h0);

        // Snap: all channels jump to distinct targets in one sweep (step is 1)
        for (int k = 0; k < NCH; k++) do_write(k, 32'h1000 * (k + 1) + 32'(k));
        do_write(11, 32'h2);
        do_tick(lat);
        chk("snap_frame_latency", 32'(lat), LAT);
        for (int k = 0; k < NCH; k++)
            chk($sformatf("snap_vol_ch%0d", k), 32'(vol_out[k*VW +: VW]),
                32'h1000 * (k + 1) + 32'(k));
        @(negedge clk);
        chk("snap_busy_clear", 32'(ramp_busy), 32'd0);

        // Reset asserted during slot 3 of a sweep
        for (int k = 0; k < NCH; k++) do_write(k, 32'h0123);
        do_write(11, 32'h2);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_vol_out_zero", 32'(vol_out != '0), 32'd0);
        chk("midreset_ramp_busy", 32'(ramp_busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (frame_done) pulses++;
            @(negedge clk);
        end
        chk("midreset_no_frame_done", 32'(pulses), 32'd0);
        do_read(8, rd);
        chk("midreset_master", rd, 32'h0000_00FF);
        do_read(0, rd);
        chk("midreset_target0", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
